// File: rtl/spi_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_cmd_decoder_pkg
// Brief  : Opcode values and FSM state encodings for the SPI command decoder.
// Rev    : 1.0  initial release
// ============================================================================
package spi_cmd_decoder_pkg;

    localparam logic [7:0] c_OP_NOP     = 8'h00;
    localparam logic [7:0] c_OP_INIT    = 8'h01;
    localparam logic [7:0] c_OP_WR_INV  = 8'h02;
    localparam logic [7:0] c_OP_RD_INV  = 8'h03;
    localparam logic [7:0] c_OP_WR_LEDS = 8'h04;
    localparam logic [7:0] c_OP_RD_LEDS = 8'h05;
    localparam logic [7:0] c_OP_WR_VEC  = 8'h06;
    localparam logic [7:0] c_OP_RD_VEC  = 8'h07;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARG  = 2'd1;
    localparam logic [1:0] c_ST_VRX  = 2'd2;
    localparam logic [1:0] c_ST_TX   = 2'd3;

    function automatic logic is_read_op(input logic [7:0] op);
        return (op == c_OP_RD_INV) || (op == c_OP_RD_LEDS) || (op == c_OP_RD_VEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module : spi_cmd_decoder_if
// Brief  : Read/write word handshake between spi_slave and the command decoder.
// Rev    : 1.0  initial release
// ============================================================================
interface spi_cmd_decoder_if #(
    parameter int DATA_W = 16
);
    logic              rd_data_avail;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              wr_buffer_free;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // master = spi_slave side, slave = command decoder side
    modport master (
        output rd_data_avail, rd_data, wr_buffer_free,
        input  rd_ack, wr_en, wr_data
    );
    modport slave (
        input  rd_data_avail, rd_data, wr_buffer_free,
        output rd_ack, wr_en, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module : spi_cmd_decoder
// Brief  : Decodes SPI command words, updates LED/inversion/vector registers
//          and streams response words back to the SPI slave.
// Rev    : 1.0  initial release
// ============================================================================
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int VEC_N  = 4,
    parameter int VEC_W  = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_cmd_decoder_if.slave       bus,
    output logic [15:0]            leds,
    output logic [15:0]            inv_reg,
    output logic [VEC_N*VEC_W-1:0] vec_flat,
    output logic [7:0]             bad_op_cnt
);

    localparam int         c_VEC_BITS  = VEC_N * VEC_W;
    localparam int         c_VEC_WORDS = c_VEC_BITS / DATA_W;
    localparam logic [2:0] c_VEC_LAST  = 3'(c_VEC_WORDS - 1);
    localparam logic [2:0] c_VEC_CNT   = 3'(c_VEC_WORDS);

    logic [c_ST_W-1:0]            r_state;
    logic [c_ST_W-1:0]            w_state_nxt;
    logic                         r_avail_q;
    logic                         w_accept;
    logic [7:0]                   w_opcode;
    logic                         r_arg_leds;
    logic [2:0]                   r_wcnt;
    logic [2:0]                   r_tx_left;
    logic [c_VEC_BITS-DATA_W-1:0] r_shadow;
    logic [c_VEC_BITS-1:0]        r_tx_buf;
    logic [c_VEC_BITS-1:0]        r_vec;
    logic [15:0]                  r_leds;
    logic [15:0]                  r_inv;
    logic [7:0]                   r_bad;
    logic                         r_gap;
    logic [DATA_W-1:0]            r_wr_last;
    logic [DATA_W-1:0]            w_tx_word;
    logic                         w_wr_en;

    assign w_accept  = bus.rd_data_avail & ~r_avail_q;
    assign w_opcode  = bus.rd_data[7:0];
    assign w_tx_word = r_tx_buf[c_VEC_BITS-1 -: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_opcode == c_OP_WR_INV || w_opcode == c_OP_WR_LEDS)
                        w_state_nxt = c_ST_ARG;
                    else if (w_opcode == c_OP_WR_VEC)
                        w_state_nxt = c_ST_VRX;
                    else if (is_read_op(w_opcode))
                        w_state_nxt = c_ST_TX;
                end
            end
            c_ST_ARG: if (w_accept) w_state_nxt = c_ST_IDLE;
            c_ST_VRX: if (w_accept && r_wcnt == c_VEC_LAST) w_state_nxt = c_ST_IDLE;
            c_ST_TX:  if (w_wr_en && r_tx_left == 3'd1) w_state_nxt = c_ST_IDLE;
            default:  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // r_gap blocks back-to-back pulses and delays the first pulse after TX entry
    always_comb begin
        bus.rd_ack  = w_accept;
        w_wr_en     = (r_state == c_ST_TX) && bus.wr_buffer_free && !r_gap
                      && (r_tx_left != 3'd0);
        bus.wr_en   = w_wr_en;
        bus.wr_data = w_wr_en ? w_tx_word : r_wr_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_avail_q  <= 1'b0;
            r_arg_leds <= 1'b0;
            r_wcnt     <= 3'd0;
            r_tx_left  <= 3'd0;
            r_shadow   <= '0;
            r_tx_buf   <= '0;
            r_vec      <= '0;
            r_leds     <= '0;
            r_inv      <= '0;
            r_bad      <= '0;
            r_gap      <= 1'b0;
            r_wr_last  <= '0;
        end else begin
            r_avail_q <= bus.rd_data_avail;
            r_gap     <= w_wr_en;
            if (w_wr_en) begin
                r_wr_last <= w_tx_word;
                r_tx_buf  <= r_tx_buf << DATA_W;
                r_tx_left <= r_tx_left - 3'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        case (w_opcode)
                            c_OP_NOP: ;
                            c_OP_INIT: begin
                                r_leds <= '0;
                                r_inv  <= '0;
                                r_vec  <= '0;
                                r_bad  <= '0;
                            end
                            c_OP_WR_INV:  r_arg_leds <= 1'b0;
                            c_OP_WR_LEDS: r_arg_leds <= 1'b1;
                            c_OP_WR_VEC:  r_wcnt     <= 3'd0;
                            c_OP_RD_INV: begin
                                r_tx_buf  <= {~r_inv, {(c_VEC_BITS-DATA_W){1'b0}}};
                                r_tx_left <= 3'd1;
                                r_gap     <= 1'b1;
                            end
                            c_OP_RD_LEDS: begin
                                r_tx_buf  <= {r_leds, {(c_VEC_BITS-DATA_W){1'b0}}};
                                r_tx_left <= 3'd1;
                                r_gap     <= 1'b1;
                            end
                            c_OP_RD_VEC: begin
                                r_tx_buf  <= r_vec;
                                r_tx_left <= c_VEC_CNT;
                                r_gap     <= 1'b1;
                            end
                            default: if (r_bad != 8'hFF) r_bad <= r_bad + 8'd1;
                        endcase
                    end
                end
                c_ST_ARG: begin
                    if (w_accept) begin
                        if (r_arg_leds) r_leds <= bus.rd_data;
                        else            r_inv  <= ~bus.rd_data;
                    end
                end
                c_ST_VRX: begin
                    if (w_accept) begin
                        r_shadow <= {r_shadow[c_VEC_BITS-2*DATA_W-1:0], bus.rd_data};
                        if (r_wcnt == c_VEC_LAST) begin
                            r_vec  <= {r_shadow, bus.rd_data};
                            r_wcnt <= 3'd0;
                        end else begin
                            r_wcnt <= r_wcnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign leds       = r_leds;
    assign inv_reg    = r_inv;
    assign vec_flat   = r_vec;
    assign bad_op_cnt = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_cmd_decoder
// Brief  : Directed self-checking bench for spi_cmd_decoder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_cmd_decoder;
    import spi_cmd_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] leds;
    logic [15:0] inv_reg;
    logic [95:0] vec_flat;
    logic [7:0]  bad_op_cnt;

    always #5 clk = ~clk;

    spi_cmd_decoder_if #(.DATA_W(16)) bus ();

    spi_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .leds       (leds),
        .inv_reg    (inv_reg),
        .vec_flat   (vec_flat),
        .bad_op_cnt (bad_op_cnt)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] leds;
        logic [15:0] inv;
        logic [7:0]  bad;
    } vec_t;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          ack_cnt  = 0;
    int          exp_acks = 0;
    int          stall_wr = 0;
    logic [15:0] cap_q[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.rd_ack) ack_cnt++;
        if (bus.wr_en) begin
            cap_q.push_back(bus.wr_data);
            cap_cyc.push_back(cyc);
            if (!bus.wr_buffer_free) stall_wr++;
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        @(posedge clk); #1;
        bus.rd_data       = w;
        bus.rd_data_avail = 1'b1;
        exp_acks++;
        @(posedge clk); #1;
        bus.rd_data_avail = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        for (int i = 0; i < 300 && cap_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_caps();
        cap_q.delete();
        cap_cyc.delete();
    endtask

    vec_t        tbl[10];
    logic [15:0] vw[6];
    int          t0;
    int          n2;
    int          a0;

    initial begin
        tbl[0] = '{16'h0004, 16'h0000, 16'h0000, 8'd0};
        tbl[1] = '{16'h00A5, 16'h00A5, 16'h0000, 8'd0};
        tbl[2] = '{16'h0002, 16'h00A5, 16'h0000, 8'd0};
        tbl[3] = '{16'h1234, 16'h00A5, 16'hEDCB, 8'd0};
        tbl[4] = '{16'h00FF, 16'h00A5, 16'hEDCB, 8'd1};
        tbl[5] = '{16'h12FF, 16'h00A5, 16'hEDCB, 8'd2};
        tbl[6] = '{16'h0008, 16'h00A5, 16'hEDCB, 8'd3};
        tbl[7] = '{16'h0000, 16'h00A5, 16'hEDCB, 8'd3};
        tbl[8] = '{16'h0004, 16'h00A5, 16'hEDCB, 8'd3};
        tbl[9] = '{16'h00FF, 16'h00FF, 16'hEDCB, 8'd3};
        vw = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB};

        reset              = 1'b1;
        bus.rd_data_avail  = 1'b0;
        bus.rd_data        = '0;
        bus.wr_buffer_free = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset leds", 96'(leds), 96'h0);
        check("reset inv", 96'(inv_reg), 96'h0);
        check("reset vec", vec_flat, 96'h0);
        check("reset bad", 96'(bad_op_cnt), 96'h0);
        check("reset wr_en", 96'(bus.wr_en), 96'h0);
        check("reset wr_data", 96'(bus.wr_data), 96'h0);
        check("reset rd_ack", 96'(bus.rd_ack), 96'h0);

        // Register writes, bad opcodes and a payload that must not be decoded
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].word);
            check($sformatf("tbl[%0d] leds", i), 96'(leds), 96'(tbl[i].leds));
            check($sformatf("tbl[%0d] inv", i), 96'(inv_reg), 96'(tbl[i].inv));
            check($sformatf("tbl[%0d] bad", i), 96'(bad_op_cnt), 96'(tbl[i].bad));
        end
        check("no wr_en for writes", 96'(cap_q.size()), 96'd0);

        // RD_INV with the slave busy, plus a dummy clock-out word
        clear_caps();
        bus.wr_buffer_free = 1'b0;
        send(16'h0003);
        send(16'h00FF);
        repeat (3) @(posedge clk);
        #1;
        check("rd_inv stalled", 96'(cap_q.size()), 96'd0);
        bus.wr_buffer_free = 1'b1;
        wait_caps(1);
        repeat (5) @(posedge clk);
        #1;
        check("rd_inv count", 96'(cap_q.size()), 96'd1);
        check("rd_inv word", 96'(cap_q[0]), 96'h1234);
        check("rd_inv wr_data hold", 96'(bus.wr_data), 96'h1234);
        check("dummy not decoded", 96'(bad_op_cnt), 96'd3);
        check("rd_inv state", 96'(dut.r_state), 96'(c_ST_IDLE));

        // RD_LEDS with a nonzero upper byte; first pulse latency
        clear_caps();
        send(16'h0305);
        t0 = cyc;
        wait_caps(1);
        repeat (3) @(posedge clk);
        #1;
        check("rd_leds count", 96'(cap_q.size()), 96'd1);
        check("rd_leds word", 96'(cap_q[0]), 96'h00FF);
        check("rd_leds latency>=2", 96'((cap_cyc[0] - t0) >= 2), 96'd1);

        // Vector write then read back with a stall mid-stream
        send(16'h0006);
        for (int i = 0; i < 6; i++) send(vw[i]);
        check("vec_flat", vec_flat, 96'h0011_2233_4455_6677_8899_AABB);
        check("vec words not decoded", 96'(bad_op_cnt), 96'd3);
        clear_caps();
        stall_wr = 0;
        send(16'h0007);
        wait_caps(2);
        bus.wr_buffer_free = 1'b0;
        n2 = cap_q.size();
        repeat (10) @(posedge clk);
        #1;
        check("rd_vec stall hold", 96'(cap_q.size()), 96'(n2));
        bus.wr_buffer_free = 1'b1;
        wait_caps(6);
        repeat (5) @(posedge clk);
        #1;
        check("rd_vec count", 96'(cap_q.size()), 96'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("rd_vec word%0d", i), 96'(cap_q[i]), 96'(vw[i]));
        check("wr_en while busy", 96'(stall_wr), 96'd0);
        check("rd_vec state", 96'(dut.r_state), 96'(c_ST_IDLE));

        // Saturation and INIT
        for (int i = 0; i < 260; i++) send(16'h00FF);
        check("bad saturates", 96'(bad_op_cnt), 96'd255);
        send(16'h0001);
        check("init leds", 96'(leds), 96'h0);
        check("init inv", 96'(inv_reg), 96'h0);
        check("init vec", vec_flat, 96'h0);
        check("init bad", 96'(bad_op_cnt), 96'h0);

        // Reset in the middle of a vector write
        send(16'h0004);
        send(16'h1234);
        check("pre-reset leds", 96'(leds), 96'h1234);
        send(16'h0006);
        send(16'h0011);
        send(16'h2233);
        send(16'h4455);
        clear_caps();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("mid reset vec", vec_flat, 96'h0);
        check("mid reset leds", 96'(leds), 96'h0);
        check("mid reset state", 96'(dut.r_state), 96'(c_ST_IDLE));
        send(16'h0005);
        wait_caps(1);
        repeat (3) @(posedge clk);
        #1;
        check("post reset rd count", 96'(cap_q.size()), 96'd1);
        check("post reset rd word", 96'(cap_q[0]), 96'h0000);

        // Level held high for several cycles is one word
        a0 = ack_cnt;
        @(posedge clk); #1;
        bus.rd_data       = 16'h0000;
        bus.rd_data_avail = 1'b1;
        exp_acks++;
        repeat (5) @(posedge clk);
        #1 bus.rd_data_avail = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held avail one ack", 96'(ack_cnt - a0), 96'd1);
        check("total acks", 96'(ack_cnt), 96'(exp_acks));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
